// File: rtl/core_dff_pkg.sv
// Shared constants and sizing helpers for the elastic register pipeline.
package core_dff_pkg;

  localparam bit SR_GATED_CE = 1'b1;  // S_R only acts while ce=1
  localparam bit SR_UNGATED  = 1'b0;  // S_R acts regardless of ce

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/core_dffr_stage.sv
// One pipeline stage: WIDTH-bit data register plus valid bit with reset/flush/load/drain.
module core_dffr_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] SR_VAL  = '0
) (
  input  logic             clk,
  input  logic             purst,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;

  // A stage that drains and loads on the same edge stays valid with new data.
  assign valid_d = load_i | (valid_q & ~drain_i);

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (purst) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      data_q  <= SR_VAL;
    end else begin
      valid_q <= valid_d;
      if (load_i) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/core_dffr_pipe.sv
// WIDTH x DEPTH elastic register pipeline: clock enable, sync reset/flush, valid/ready with
// combinational ready ripple and bubble collapse.
module core_dffr_pipe
  import core_dff_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter logic [WIDTH-1:0] SR_VAL   = '0,
  parameter bit               SR_GATED = SR_GATED_CE
) (
  input  logic                      clk,
  input  logic                      purst,
  input  logic                      ce,
  input  logic                      S_R,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          d,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          q,
  output logic [cnt_w(DEPTH)-1:0]   occupancy
);

  localparam int CNT_W = cnt_w(DEPTH);

  if (DEPTH < 1) begin : g_depth_check
    $error("core_dffr_pipe: DEPTH must be >= 1");
  end

  logic             sr_eff;
  logic             flow;
  logic             in_xfer;
  logic             out_xfer;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] data [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sr_eff = S_R & (ce | ~SR_GATED);
  assign flow   = ce & ~sr_eff;

  // Ready ripples back from out_ready; a bubble anywhere downstream lets a stage advance.
  always_comb begin
    logic rdy;
    adv = '0;
    rdy = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i] = flow & valid[i] & rdy;
      rdy    = ~valid[i] | adv[i];
    end
    in_ready = flow & rdy;
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = adv[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             load;
    logic [WIDTH-1:0] load_data;

    if (i == 0) begin : g_head
      assign load      = in_xfer;
      assign load_data = d;
    end else begin : g_body
      assign load      = adv[i-1];
      assign load_data = data[i-1];
    end

    core_dffr_stage #(
      .WIDTH  (WIDTH),
      .RST_VAL(RST_VAL),
      .SR_VAL (SR_VAL)
    ) u_stage (
      .clk    (clk),
      .purst  (purst),
      .flush_i(sr_eff),
      .load_i (load),
      .drain_i(adv[i]),
      .data_i (load_data),
      .valid_o(valid[i]),
      .data_o (data[i])
    );
  end

  assign cnt_d = cnt_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);

  always_ff @(posedge clk) begin
    if (purst || sr_eff) cnt_q <= '0;
    else                 cnt_q <= cnt_d;
  end

  assign occupancy = cnt_q;
  assign out_valid = ce & valid[DEPTH-1];
  assign q         = data[DEPTH-1];

endmodule

// File: tb/tb_core_dffr_pipe.sv
// Randomised and directed scoreboard bench for core_dffr_pipe (DEPTH=3, WIDTH=8).
module tb_core_dffr_pipe;

  localparam int         WIDTH    = 8;
  localparam int         DEPTH    = 3;
  localparam logic [7:0] RST_VAL  = 8'hA5;
  localparam logic [7:0] SR_VAL   = 8'h3C;
  localparam bit         SR_GATED = 1'b1;

  logic       clk = 1'b0;
  logic       purst = 1'b1;
  logic       ce = 1'b1;
  logic       S_R = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] d = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] q;
  logic [1:0] occupancy;

  int         n_checks = 0;
  int         n_errors = 0;
  bit         mon_en = 1'b0;
  logic [7:0] sb[$];
  int         model_cnt = 0;

  always #5 clk = ~clk;

  core_dffr_pipe #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (RST_VAL),
    .SR_VAL  (SR_VAL),
    .SR_GATED(SR_GATED)
  ) dut (
    .clk      (clk),
    .purst    (purst),
    .ce       (ce),
    .S_R      (S_R),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .d        (d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .occupancy(occupancy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    purst = 1'b0; S_R = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    idle_inputs();
    out_ready = 1'b1;
    repeat (DEPTH + 4) step();
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_occ_zero"}, occupancy, 0);
    out_ready = 1'b0;
  endtask

  // Monitor: reference model is a FIFO of accepted words plus a word count.
  always @(negedge clk) begin
    if (mon_en) begin
      bit sr_eff, flow, exp_rdy, in_x, out_x;
      sr_eff  = S_R && (ce || !SR_GATED);
      flow    = ce && !sr_eff;
      exp_rdy = flow && (model_cnt < DEPTH || out_ready);
      check("mon_occupancy", occupancy, model_cnt);
      check("mon_in_ready", in_ready, exp_rdy);
      if (!ce) check("mon_out_valid_ce0", out_valid, 0);
      if (ce && model_cnt == DEPTH) check("mon_out_valid_full", out_valid, 1);
      in_x  = in_valid && exp_rdy;
      out_x = out_valid && out_ready;
      if (out_x) begin
        if (sb.size() == 0) check("mon_out_when_empty", out_x, 0);
        else                check("mon_q_data", q, sb.pop_front());
      end
      if (purst || sr_eff) begin
        sb.delete();
        model_cnt = 0;
      end else begin
        if (in_x) sb.push_back(d);
        model_cnt = model_cnt + int'(in_x) - int'(out_x && sb.size() + 1 > 0);
      end
    end
  end

  initial begin
    int lat;
    int accepts;

    // 1: reset
    step(); step();
    purst = 1'b0;
    #1;
    check("rst_q", q, RST_VAL);
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready", in_ready, 1);
    mon_en = 1'b1;

    // 2a: single-word latency through an empty pipe
    out_ready = 1'b1; in_valid = 1'b1; d = 8'h77;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("latency_edges", lat, DEPTH);
    drain("lat");

    // 2b: continuous stream 01..10
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_valid = 1'b1; d = 8'(k);
      step();
      if (k >= DEPTH) check("stream_occ_steady", occupancy, DEPTH);
    end
    drain("stream");

    // 3: fill with out_ready=0, then release
    accepts = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; d = 8'h20 + 8'(k);
      #1;
      if (in_ready) accepts++;
      step();
    end
    check("stall_accepts", accepts, DEPTH);
    check("stall_occ", occupancy, DEPTH);
    check("stall_in_ready", in_ready, 0);
    drain("stall");

    // 4: bubble collapse
    in_valid = 1'b1; d = 8'h41; step();
    in_valid = 1'b0;            step();
    in_valid = 1'b1; d = 8'h42; step();
    in_valid = 1'b0;            step();
    check("bubble_occ", occupancy, 2);
    out_ready = 1'b1;
    #1;
    check("bubble_out0_valid", out_valid, 1);
    check("bubble_out0_q", q, 8'h41);
    step();
    check("bubble_out1_valid", out_valid, 1);
    check("bubble_out1_q", q, 8'h42);
    step();
    check("bubble_out2_valid", out_valid, 0);
    drain("bubble");

    // 5a: flush mid-stream, input that cycle is dropped
    in_valid = 1'b1; d = 8'h51; step();
    d = 8'h52; step();
    S_R = 1'b1; d = 8'h99; step();
    S_R = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_out_valid", out_valid, 0);
    check("flush_q", q, SR_VAL);
    check("flush_occ", occupancy, 0);
    step();
    check("flush_dropped_occ", occupancy, 0);

    // 5b: gated S_R with ce=0 is ignored
    in_valid = 1'b1; d = 8'h61; step();
    d = 8'h62; step();
    in_valid = 1'b0; ce = 1'b0; S_R = 1'b1; step();
    check("gated_sr_occ", occupancy, 2);
    check("gated_sr_out_valid", out_valid, 0);
    ce = 1'b1; S_R = 1'b0;
    #1;
    check("gated_sr_resume_occ", occupancy, 2);
    drain("gated_sr");

    // 6: clock enable freeze on a full pipe
    in_valid = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      d = 8'h70 + 8'(k); step();
    end
    ce = 1'b0; out_ready = 1'b1; d = 8'hEE;
    for (int k = 0; k < 4; k++) begin
      step();
      check("ce0_in_ready", in_ready, 0);
      check("ce0_out_valid", out_valid, 0);
      check("ce0_occ", occupancy, DEPTH);
    end
    drain("ce0");

    // Random traffic, including occasional ce drops, flushes and resets
    for (int c = 0; c < 400; c++) begin
      ce        = ($urandom_range(0, 9) != 0);
      S_R       = ($urandom_range(0, 39) == 0);
      purst     = ($urandom_range(0, 79) == 0);
      in_valid  = $urandom_range(0, 1);
      d         = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (S_R || purst) out_ready = 1'b0;
      step();
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
